// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Programmable-rate prescaler plus a pattern FSM that drives an LED vector
//   through one of four display modes (COUNT, SHIFT, BOUNCE, BLINK). Mode and
//   rate are reconfigured at run time through a valid/ready port.
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   asynchronous active-high reset
//   enable     in   run request; low returns to IDLE with LEDs dark
//   cfg_valid  in   configuration offered
//   cfg_ready  out  combinational; low only during the one-cycle SWITCH state
//   cfg_mode   in   0 COUNT, 1 SHIFT, 2 BOUNCE, 3 BLINK
//   cfg_rate   in   log2 cycles per step; values above LOG2DELAY clamp
//   led        out  registered pattern
//   tick       out  registered; high in each cycle led shows a new step
module led_pattern_sequencer #(
  parameter int unsigned BITS      = 4,
  parameter int unsigned LOG2DELAY = 22
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [1:0]      cfg_mode,
  input  logic [4:0]      cfg_rate,
  output logic [BITS-1:0] led,
  output logic            tick
);

  localparam int unsigned PW  = LOG2DELAY;
  localparam int unsigned PW1 = LOG2DELAY + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;

  localparam logic [1:0] MODE_COUNT  = 2'd0;
  localparam logic [1:0] MODE_SHIFT  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  localparam logic [4:0] MAX_RATE = 5'(LOG2DELAY);

  logic [1:0]      state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [4:0]      rate_q, rate_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BITS-1:0] led_q, led_d;
  logic            tick_q, tick_d;
  logic            dir_up_q, dir_up_d;

  logic            cfg_accept;
  logic            step;
  logic [PW1-1:0]  rate_onehot;
  logic [PW-1:0]   rate_mask;
  logic [BITS-1:0] led_step;
  logic            dir_step;

  function automatic logic [BITS-1:0] seed_of(input logic [1:0] m);
    return (m == MODE_SHIFT || m == MODE_BOUNCE) ? BITS'(1) : '0;
  endfunction

  assign cfg_ready  = (state_q != ST_SWITCH);
  assign cfg_accept = cfg_valid && cfg_ready;

  // Step when the low rate bits of the prescaler are all ones; rate 0 gives an
  // empty mask, so every RUN cycle is a step.
  assign rate_onehot = PW1'(1) << rate_q;
  assign rate_mask   = PW'(rate_onehot - PW1'(1));
  assign step        = (state_q == ST_RUN) && ((presc_q & rate_mask) == rate_mask);

  // Next pattern for the current mode.
  always_comb begin
    led_step = led_q;
    dir_step = dir_up_q;
    case (mode_q)
      MODE_COUNT:  led_step = led_q + BITS'(1);
      MODE_SHIFT:  led_step = {led_q[BITS-2:0], led_q[BITS-1]};
      MODE_BOUNCE: begin
        if (dir_up_q) begin
          if (led_q[BITS-1]) begin
            led_step = led_q >> 1;
            dir_step = 1'b0;
          end else begin
            led_step = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            led_step = led_q << 1;
            dir_step = 1'b1;
          end else begin
            led_step = led_q >> 1;
          end
        end
      end
      MODE_BLINK:  led_step = ~led_q;
      default:     led_step = led_q;
    endcase
  end

  // Next-state logic; priority is cfg accept, then enable drop, then step.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rate_d   = rate_q;
    presc_d  = presc_q;
    led_d    = led_q;
    tick_d   = 1'b0;
    dir_up_d = dir_up_q;

    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        led_d   = '0;
        if (cfg_accept) begin
          mode_d  = cfg_mode;
          rate_d  = (cfg_rate > MAX_RATE) ? MAX_RATE : cfg_rate;
          state_d = ST_SWITCH;
        end else if (enable) begin
          state_d  = ST_RUN;
          led_d    = seed_of(mode_q);
          dir_up_d = 1'b1;
        end
      end

      ST_RUN: begin
        presc_d = presc_q + PW'(1);
        if (cfg_accept) begin
          mode_d   = cfg_mode;
          rate_d   = (cfg_rate > MAX_RATE) ? MAX_RATE : cfg_rate;
          state_d  = ST_SWITCH;
          presc_d  = '0;
          led_d    = seed_of(cfg_mode);
          dir_up_d = 1'b1;
        end else if (!enable) begin
          state_d = ST_IDLE;
          presc_d = '0;
          led_d   = '0;
        end else if (step) begin
          led_d    = led_step;
          dir_up_d = dir_step;
          tick_d   = 1'b1;
        end
      end

      ST_SWITCH: begin
        presc_d = '0;
        if (enable) begin
          state_d  = ST_RUN;
          led_d    = seed_of(mode_q);
          dir_up_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          led_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        presc_d = '0;
        led_d   = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_COUNT;
      rate_q   <= MAX_RATE;
      presc_q  <= '0;
      led_q    <= '0;
      tick_q   <= 1'b0;
      dir_up_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      rate_q   <= rate_d;
      presc_q  <= presc_d;
      led_q    <= led_d;
      tick_q   <= tick_d;
      dir_up_q <= dir_up_d;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
//   Self-checking bench for led_pattern_sequencer (BITS=4, LOG2DELAY=3).
//   Expected {led, tick} per cycle is queued ahead of time and compared at
//   each falling edge.
module tb_led_pattern_sequencer;

  localparam int unsigned BITS      = 4;
  localparam int unsigned LOG2DELAY = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [1:0]      cfg_mode;
  logic [4:0]      cfg_rate;
  logic [BITS-1:0] led;
  logic            tick;

  led_pattern_sequencer #(.BITS(BITS), .LOG2DELAY(LOG2DELAY)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_rate  (cfg_rate),
    .led       (led),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] led;
    logic       tick;
  } exp_t;

  typedef struct packed {
    logic [1:0]      mode;
    logic [4:0]      rate;
    logic [7:0]      period;
    logic [0:7][3:0] seq;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act !== expv) $display("FAIL %s: got %0h expected %0h", name, act, expv);
    else n_pass++;
  endtask

  // Closed-form pattern after k steps from the seed (BITS=4).
  function automatic logic [3:0] pat(input logic [1:0] mode, input int k);
    int pos;
    case (mode)
      2'd0: return 4'(k % 16);
      2'd1: return 4'(1 << (k % 4));
      2'd2: begin
        case (k % 6)
          0: pos = 0;
          1: pos = 1;
          2: pos = 2;
          3: pos = 3;
          4: pos = 2;
          default: pos = 1;
        endcase
        return 4'(1 << pos);
      end
      default: return ((k % 2) == 1) ? 4'hF : 4'h0;
    endcase
  endfunction

  task automatic push(input logic [3:0] l, input logic t);
    exp_t e;
    e.led  = l;
    e.tick = t;
    sb_q.push_back(e);
  endtask

  // RUN cycles jf..jl after entering RUN, step period p.
  task automatic push_run(input logic [1:0] mode, input int p, input int jf, input int jl);
    for (int j = jf; j <= jl; j++) push(pat(mode, j / p), (j > 0) && (j % p == 0));
  endtask

  task automatic check_cycles(input string tag, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        check($sformatf("%s_empty_c%0d", tag, i), 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        check($sformatf("%s_c%0d", tag, i), 32'({led, tick}), 32'({e.led, e.tick}));
      end
    end
  endtask

  // Offer one config; returns at the falling edge of the SWITCH cycle.
  task automatic cfg_apply(input string tag, input logic [1:0] m, input logic [4:0] r);
    @(posedge clk);
    #1;
    cfg_valid = 1'b1;
    cfg_mode  = m;
    cfg_rate  = r;
    @(negedge clk);
    check({tag, "_ready_hi"}, 32'(cfg_ready), 32'(1));
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    check({tag, "_ready_lo"}, 32'(cfg_ready), 32'(0));
    check({tag, "_switch_tick"}, 32'(tick), 32'(0));
  endtask

  initial begin
    vecs[0] = '{mode: 2'd0, rate: 5'd1,  period: 8'd2, seq: {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7}};
    vecs[1] = '{mode: 2'd1, rate: 5'd0,  period: 8'd1, seq: {4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8}};
    vecs[2] = '{mode: 2'd2, rate: 5'd0,  period: 8'd1, seq: {4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2}};
    vecs[3] = '{mode: 2'd3, rate: 5'd1,  period: 8'd2, seq: {4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF}};
    vecs[4] = '{mode: 2'd2, rate: 5'd31, period: 8'd8, seq: {4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2}};
    vecs[5] = '{mode: 2'd1, rate: 5'd4,  period: 8'd8, seq: {4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8}};
    vecs[6] = '{mode: 2'd0, rate: 5'd3,  period: 8'd8, seq: {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7}};

    rst       = 1'b1;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_mode  = 2'd0;
    cfg_rate  = 5'd0;

    // Reset values.
    @(negedge clk);
    check("reset_led", 32'(led), 32'(0));
    check("reset_tick", 32'(tick), 32'(0));
    check("reset_ready", 32'(cfg_ready), 32'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Config while idle and disabled: SWITCH falls back to IDLE.
    cfg_apply("cfg_idle", 2'd0, 5'd2);
    push(4'h0, 1'b0);
    push(4'h0, 1'b0);
    check_cycles("idle_hold", 2);

    // COUNT rate 2: a step every 4 cycles, full wrap back to 0.
    @(posedge clk);
    #1;
    enable = 1'b1;
    push(4'h0, 1'b0);
    push_run(2'd0, 4, 0, 64);
    check_cycles("count_wrap", 66);

    // Config offered in a step cycle: step suppressed, BLINK seed shown.
    cfg_apply("cfg_count", 2'd0, 5'd2);
    push_run(2'd0, 4, 0, 10);
    check_cycles("pre_step", 11);
    @(posedge clk);
    #1;
    cfg_valid = 1'b1;
    cfg_mode  = 2'd3;
    cfg_rate  = 5'd1;
    @(negedge clk);
    check("stepcyc_led", 32'(led), 32'(2));
    check("stepcyc_ready", 32'(cfg_ready), 32'(1));
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    check("supp_tick", 32'(tick), 32'(0));
    check("supp_ready", 32'(cfg_ready), 32'(0));
    check("supp_seed", 32'(led), 32'(0));
    push_run(2'd3, 2, 0, 6);
    check_cycles("blink_run", 7);

    // Enable drop in a BLINK step cycle: dark next edge, no tick.
    @(posedge clk);
    #1;
    enable = 1'b0;
    push(4'hF, 1'b0);
    push(4'h0, 1'b0);
    push(4'h0, 1'b0);
    push(4'h0, 1'b0);
    check_cycles("en_drop", 4);
    check("idle_ready", 32'(cfg_ready), 32'(1));

    // Re-enable: BLINK seed 0, then toggles.
    @(posedge clk);
    #1;
    enable = 1'b1;
    push(4'h0, 1'b0);
    push_run(2'd3, 2, 0, 3);
    check_cycles("reenable", 5);

    // Asynchronous reset mid-run with led lit.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_led", 32'(led), 32'(0));
    check("async_rst_tick", 32'(tick), 32'(0));
    check("async_rst_ready", 32'(cfg_ready), 32'(1));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Config lost: COUNT at default rate (8 cycles per step).
    push(4'h0, 1'b0);
    push_run(2'd0, 8, 0, 16);
    check_cycles("post_rst", 18);

    // Table of mode/rate vectors, applied while running.
    for (int v = 0; v < 7; v++) begin
      int p;
      p = int'(vecs[v].period);
      cfg_apply($sformatf("vec%0d_cfg", v), vecs[v].mode, vecs[v].rate);
      for (int j = 0; j < 8 * p; j++) push(vecs[v].seq[j / p], (j > 0) && (j % p == 0));
      check_cycles($sformatf("vec%0d", v), 8 * p);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
